// File: rtl/l2_mem_ctrl_pkg.sv
// Shared L2 definitions: line geometry and miss-controller state encoding.
package l2_mem_ctrl_pkg;

   localparam int INDEX_W = 8;
   localparam int TAG_W   = 18;
   localparam int LINE_W  = 512;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WB   = 3'd1,
      GAP  = 3'd2,
      RD   = 3'd3,
      DONE = 3'd4
   } l2_state_t;

endpackage

// File: rtl/l2_mem_ctrl.sv
// L2 miss controller: optional dirty-victim write-back, one idle gap cycle,
// then a refill read. Each memory request is a level held until the one-cycle
// ready pulse, guarded by a watchdog that aborts after TIMEOUT cycles.
module l2_mem_ctrl
   import l2_mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               req_L2,
   input  logic [INDEX_W-1:0] index_L2,
   input  logic [TAG_W-1:0]   tag_L2,
   input  logic               dirty_L2,
   input  logic [TAG_W-1:0]   victim_tag_L2,
   input  logic [LINE_W-1:0]  victim_data_L2,
   output logic               read_L2_MEM,
   output logic               write_L2_MEM,
   output logic [INDEX_W-1:0] index_L2_MEM,
   output logic [TAG_W-1:0]   tag_L2_MEM,
   output logic [LINE_W-1:0]  write_data_L2_MEM,
   input  logic               ready_MEM_L2,
   input  logic [LINE_W-1:0]  read_data_MEM_L2,
   output logic [LINE_W-1:0]  refill_data_L2,
   output logic               done_L2,
   output logic               err_L2,
   output logic               busy_L2
);

   // Sized so that TIMEOUT itself is representable; the counter never wraps.
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

   l2_state_t          state;
   logic [CNT_W-1:0]   wdog_cnt;
   logic [INDEX_W-1:0] miss_index;
   logic [TAG_W-1:0]   miss_tag;

   // Busy is a pure state decode, so it carries no path from ready.
   assign busy_L2 = (state != IDLE);

   // Miss FSM with registered request outputs; each transition loads the
   // outputs for the state being entered, so nothing depends on ready combinationally.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state             <= IDLE;
         wdog_cnt          <= '0;
         read_L2_MEM       <= 1'b0;
         write_L2_MEM      <= 1'b0;
         index_L2_MEM      <= '0;
         tag_L2_MEM        <= '0;
         write_data_L2_MEM <= '0;
         refill_data_L2    <= '0;
         done_L2           <= 1'b0;
         err_L2            <= 1'b0;
      end else begin
         done_L2 <= 1'b0;
         err_L2  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_L2) begin
                  miss_index   <= index_L2;
                  miss_tag     <= tag_L2;
                  index_L2_MEM <= index_L2;
                  wdog_cnt     <= '0;
                  if (dirty_L2) begin
                     state             <= WB;
                     write_L2_MEM      <= 1'b1;
                     tag_L2_MEM        <= victim_tag_L2;
                     write_data_L2_MEM <= victim_data_L2;
                  end else begin
                     state       <= RD;
                     read_L2_MEM <= 1'b1;
                     tag_L2_MEM  <= tag_L2;
                  end
               end
            end
            WB: begin
               // Ready takes priority over a watchdog expiry in the same cycle.
               if (ready_MEM_L2 || (wdog_cnt == WDOG_LAST)) begin
                  state             <= ready_MEM_L2 ? GAP : IDLE;
                  err_L2            <= !ready_MEM_L2;
                  write_L2_MEM      <= 1'b0;
                  index_L2_MEM      <= '0;
                  tag_L2_MEM        <= '0;
                  write_data_L2_MEM <= '0;
               end else begin
                  wdog_cnt <= wdog_cnt + 1'b1;
               end
            end
            GAP: begin
               // Memory needs one deasserted cycle between back-to-back requests.
               state        <= RD;
               read_L2_MEM  <= 1'b1;
               index_L2_MEM <= miss_index;
               tag_L2_MEM   <= miss_tag;
               wdog_cnt     <= '0;
            end
            RD: begin
               if (ready_MEM_L2) begin
                  state          <= DONE;
                  done_L2        <= 1'b1;
                  refill_data_L2 <= read_data_MEM_L2;
                  read_L2_MEM    <= 1'b0;
                  index_L2_MEM   <= '0;
                  tag_L2_MEM     <= '0;
               end else if (wdog_cnt == WDOG_LAST) begin
                  state        <= IDLE;
                  err_L2       <= 1'b1;
                  read_L2_MEM  <= 1'b0;
                  index_L2_MEM <= '0;
                  tag_L2_MEM   <= '0;
               end else begin
                  wdog_cnt <= wdog_cnt + 1'b1;
               end
            end
            DONE: begin
               // A held req_L2 is deliberately not accepted here.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// Bench for l2_mem_ctrl: each miss is turned into an expected per-cycle
// schedule of interface activity built from the protocol rules, the bench
// plays the memory side from that schedule, and outputs are compared every cycle.
module tb_l2_mem_ctrl;

   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         rstn;
   logic         req_L2;
   logic [7:0]   index_L2;
   logic [17:0]  tag_L2;
   logic         dirty_L2;
   logic [17:0]  victim_tag_L2;
   logic [511:0] victim_data_L2;
   logic         read_L2_MEM;
   logic         write_L2_MEM;
   logic [7:0]   index_L2_MEM;
   logic [17:0]  tag_L2_MEM;
   logic [511:0] write_data_L2_MEM;
   logic         ready_MEM_L2;
   logic [511:0] read_data_MEM_L2;
   logic [511:0] refill_data_L2;
   logic         done_L2;
   logic         err_L2;
   logic         busy_L2;

   int total = 0;
   int bad   = 0;
   logic [511:0] exp_refill;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [17:0] tag;
      logic        dn;
      logic        er;
      logic        bsy;
      logic        rdy;
   } step_t;

   l2_mem_ctrl #(.TIMEOUT(TO)) dut (
      .clk               (clk),
      .rstn              (rstn),
      .req_L2            (req_L2),
      .index_L2          (index_L2),
      .tag_L2            (tag_L2),
      .dirty_L2          (dirty_L2),
      .victim_tag_L2     (victim_tag_L2),
      .victim_data_L2    (victim_data_L2),
      .read_L2_MEM       (read_L2_MEM),
      .write_L2_MEM      (write_L2_MEM),
      .index_L2_MEM      (index_L2_MEM),
      .tag_L2_MEM        (tag_L2_MEM),
      .write_data_L2_MEM (write_data_L2_MEM),
      .ready_MEM_L2      (ready_MEM_L2),
      .read_data_MEM_L2  (read_data_MEM_L2),
      .refill_data_L2    (refill_data_L2),
      .done_L2           (done_L2),
      .err_L2            (err_L2),
      .busy_L2           (busy_L2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic logic [511:0] rand_line();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic step_t mk(input logic rd, input logic wr, input logic [17:0] tg,
                                input logic dn, input logic er, input logic bsy, input logic rdy);
      step_t s;
      s.rd = rd; s.wr = wr; s.tag = tg; s.dn = dn; s.er = er; s.bsy = bsy; s.rdy = rdy;
      return s;
   endfunction

   // lat = request cycles that pass without ready before the ready cycle;
   // lat >= TO means memory never answers. rline = 0 selects random refill data.
   task automatic do_miss(input bit dirty, input int wlat, input int rlat, input bit keep,
                          input bit gap_rdy, input logic [7:0] idx, input logic [17:0] tg,
                          input logic [17:0] vtg, input logic [511:0] vd,
                          input logic [511:0] rline);
      step_t q[$];
      bit ok;
      logic [511:0] rd_now;
      ok = 1;
      if (dirty) begin
         for (int i = 0; i < TO && i <= wlat; i++)
            q.push_back(mk(1'b0, 1'b1, vtg, 1'b0, 1'b0, 1'b1, (i == wlat)));
         if (wlat >= TO) begin
            q.push_back(mk(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0));
            ok = 0;
         end else begin
            q.push_back(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, gap_rdy));
         end
      end
      if (ok) begin
         for (int i = 0; i < TO && i <= rlat; i++)
            q.push_back(mk(1'b1, 1'b0, tg, 1'b0, 1'b0, 1'b1, (i == rlat)));
         if (rlat >= TO) q.push_back(mk(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0));
         else            q.push_back(mk(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0));
      end

      @(negedge clk);
      chk("idle_busy", busy_L2, 1'b0);
      chk("idle_rd", read_L2_MEM, 1'b0);
      req_L2 = 1'b1; index_L2 = idx; tag_L2 = tg; dirty_L2 = dirty;
      victim_tag_L2 = vtg; victim_data_L2 = vd; ready_MEM_L2 = 1'b0;

      foreach (q[k]) begin
         @(negedge clk);
         chk($sformatf("rd[%0d]", k),    read_L2_MEM, q[k].rd);
         chk($sformatf("wr[%0d]", k),    write_L2_MEM, q[k].wr);
         chk($sformatf("tag[%0d]", k),   tag_L2_MEM, q[k].tag);
         chk($sformatf("idx[%0d]", k),   index_L2_MEM, (q[k].rd || q[k].wr) ? idx : 8'h00);
         chk($sformatf("wdata[%0d]", k), write_data_L2_MEM, q[k].wr ? vd : '0);
         chk($sformatf("done[%0d]", k),  done_L2, q[k].dn);
         chk($sformatf("err[%0d]", k),   err_L2, q[k].er);
         chk($sformatf("busy[%0d]", k),  busy_L2, q[k].bsy);
         chk($sformatf("refill[%0d]", k), refill_data_L2, exp_refill);
         rd_now = (rline != '0) ? rline : rand_line();
         read_data_MEM_L2 = rd_now;
         ready_MEM_L2 = q[k].rdy;
         if (q[k].rd && q[k].rdy) exp_refill = rd_now;
         if ((q[k].dn || q[k].er) && !keep) req_L2 = 1'b0;
      end
   endtask

   task automatic idle_spurious();
      @(negedge clk);
      req_L2 = 1'b0; ready_MEM_L2 = 1'b1; read_data_MEM_L2 = rand_line();
      @(negedge clk);
      ready_MEM_L2 = 1'b0;
      chk("spur_busy", busy_L2, 1'b0);
      chk("spur_rd", read_L2_MEM, 1'b0);
      chk("spur_refill", refill_data_L2, exp_refill);
   endtask

   initial begin
      logic [511:0] a5, v11;
      a5  = {64{8'hA5}};
      v11 = {64{8'h11}};
      rstn = 1'b0; req_L2 = 1'b0; index_L2 = '0; tag_L2 = '0; dirty_L2 = 1'b0;
      victim_tag_L2 = '0; victim_data_L2 = '0; ready_MEM_L2 = 1'b0; read_data_MEM_L2 = '0;
      exp_refill = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy_L2, 1'b0);
      chk("rst_rd", read_L2_MEM, 1'b0);
      chk("rst_wr", write_L2_MEM, 1'b0);
      chk("rst_refill", refill_data_L2, '0);
      chk("rst_done", done_L2, 1'b0);
      chk("rst_err", err_L2, 1'b0);
      rstn = 1'b1;

      // Clean miss against a one-cycle memory.
      do_miss(1'b0, 0, 1, 1'b0, 1'b0, 8'h05, 18'h0, 18'h0, '0, a5);
      chk("clean_line", refill_data_L2, a5);
      // Dirty miss with one-cycle memory on both transfers; spurious ready in GAP.
      do_miss(1'b1, 1, 1, 1'b0, 1'b1, 8'h2C, 18'h1ABCD, 18'h3, v11, '0);
      // Memory never answers the read, then never answers a write-back.
      do_miss(1'b0, 0, 100, 1'b0, 1'b0, 8'h11, 18'h00777, 18'h0, '0, '0);
      do_miss(1'b1, 100, 0, 1'b0, 1'b0, 8'h12, 18'h00123, 18'h2222, rand_line(), '0);
      // Ready exactly on the watchdog's last cycle completes normally.
      do_miss(1'b1, TO-1, TO-1, 1'b0, 1'b0, 8'h44, 18'h3FFFF, 18'h15555, rand_line(), '0);
      idle_spurious();

      // Reset while in RD.
      @(negedge clk);
      req_L2 = 1'b1; dirty_L2 = 1'b0; index_L2 = 8'h77; tag_L2 = 18'h0BEEF;
      repeat (3) @(negedge clk);
      chk("mid_rd", read_L2_MEM, 1'b1);
      rstn = 1'b0; req_L2 = 1'b0;
      @(negedge clk);
      exp_refill = '0;
      chk("rst_mid_rd", read_L2_MEM, 1'b0);
      chk("rst_mid_idx", index_L2_MEM, 8'h00);
      chk("rst_mid_tag", tag_L2_MEM, 18'h0);
      chk("rst_mid_busy", busy_L2, 1'b0);
      chk("rst_mid_refill", refill_data_L2, '0);
      rstn = 1'b1;
      do_miss(1'b0, 0, 2, 1'b0, 1'b0, 8'h78, 18'h0CAFE, 18'h0, '0, '0);

      // Back-to-back misses with req held through DONE.
      do_miss(1'b0, 0, 1, 1'b1, 1'b0, 8'h01, 18'h00001, 18'h0, '0, '0);
      do_miss(1'b0, 0, 1, 1'b0, 1'b0, 8'h02, 18'h00002, 18'h0, '0, '0);

      // Randomized misses, including occasional timeouts.
      for (int n = 0; n < 25; n++) begin
         do_miss(1'($urandom_range(0, 1)), $urandom_range(0, TO + 1), $urandom_range(0, TO + 1),
                 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 18'($urandom), 18'($urandom),
                 rand_line(), '0);
         if ($urandom_range(0, 3) == 0) idle_spurious();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "bench timeout");
   end

endmodule
